// File: rtl/func_eval_pkg.sv
// Shared constants and the in-flight tag type for the function-evaluation scheduler.
package func_eval_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int KLAT_DEF  = 3;
  localparam int NREQ_DEF  = 4;
  localparam int NREQ_MAX  = 8;

  // Owner field is sized for the largest legal requester count, so one tag type serves every build.
  localparam int IDX_W = $clog2(NREQ_MAX);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] owner;
  } tag_t;

endpackage

// File: rtl/func_eval_sched_rr_arbiter.sv
// Round-robin arbiter: first eligible index at or above ptr (with wrap) wins, one-hot grant plus its index.
module rr_arbiter
  import func_eval_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  int idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (j == idx) && eligible[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          winner   = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/func_eval_sched.sv
// Time-shares one fixed-latency sqrt(sin(x)) kernel between NREQ requesters and routes results back by tag.
// Build option FUNC_EVAL_SCHED_PRIO0_EN gives requester 0 strict priority over the round-robin.
module func_eval_sched
  import func_eval_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int KLAT  = KLAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_x,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       busy,
  output logic [WIDTH-1:0]      k_x,
  output logic                  k_valid,
  input  logic [WIDTH-1:0]      k_y,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_y
);

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  arb_elig;
  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_win;
  logic             arb_found;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic             any_gnt;
  logic             upd_ptr;
  logic [WIDTH-1:0] win_x;
  logic [IDX_W-1:0] k_owner;
  tag_t             tag_pipe [KLAT];
  tag_t             tag_out;
  logic [NREQ-1:0]  clr_mask;

  // Gating with rst_n keeps the combinational grant quiet while reset is held.
  assign eligible = req & ~busy & {NREQ{rst_n}};

`ifdef FUNC_EVAL_SCHED_PRIO0_EN
  assign arb_elig = eligible & ~NREQ'(1);
`else
  assign arb_elig = eligible;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .eligible (arb_elig),
    .ptr      (ptr),
    .grant    (arb_gnt),
    .winner   (arb_win),
    .found    (arb_found)
  );

`ifdef FUNC_EVAL_SCHED_PRIO0_EN
  always_comb begin
    if (eligible[0]) begin
      gnt     = NREQ'(1);
      win     = '0;
      any_gnt = 1'b1;
      upd_ptr = 1'b0;
    end else begin
      gnt     = arb_gnt;
      win     = arb_win;
      any_gnt = arb_found;
      upd_ptr = arb_found;
    end
  end
`else
  assign gnt     = arb_gnt;
  assign win     = arb_win;
  assign any_gnt = arb_found;
  assign upd_ptr = arb_found;
`endif

  always_comb begin
    win_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDX_W'(i)) win_x = req_x[i*WIDTH +: WIDTH];
    end
  end

  assign tag_out = tag_pipe[KLAT-1];

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (tag_out.valid && (tag_out.owner == IDX_W'(i))) clr_mask[i] = 1'b1;
    end
  end

  // The issue register (k_valid/k_owner) feeds KLAT tag stages, so the last stage
  // lines up with the cycle the kernel presents the matching result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      busy      <= '0;
      k_x       <= '0;
      k_valid   <= 1'b0;
      k_owner   <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      for (int i = 0; i < KLAT; i++) tag_pipe[i] <= '0;
    end else begin
      k_valid <= any_gnt;
      if (any_gnt) begin
        k_x     <= win_x;
        k_owner <= win;
      end
      if (upd_ptr) ptr <= (int'(win) == NREQ-1) ? '0 : win + IDX_W'(1);
      busy <= (busy | gnt) & ~clr_mask;
      tag_pipe[0].valid <= k_valid;
      tag_pipe[0].owner <= k_owner;
      for (int i = 1; i < KLAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      rsp_valid <= clr_mask;
      if (tag_out.valid) rsp_y <= k_y;
    end
  end

endmodule

// File: tb/tb_func_eval_sched.sv
// Directed bench for func_eval_sched with a stub kernel y = x + 1 of latency KLAT.
module tb_func_eval_sched;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int KLAT  = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_x = '0;
  logic [NREQ-1:0]       gnt, busy, rsp_valid;
  logic [WIDTH-1:0]      k_x, k_y, rsp_y;
  logic                  k_valid;
  logic [WIDTH-1:0]      kpipe [KLAT];

  int checks = 0;
  int errors = 0;

  func_eval_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .KLAT(KLAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_x     (req_x),
    .gnt       (gnt),
    .busy      (busy),
    .k_x       (k_x),
    .k_valid   (k_valid),
    .k_y       (k_y),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y)
  );

  always #5 clk = ~clk;

  // Stub kernel: result appears KLAT cycles after the K_VALID cycle; garbage otherwise.
  always @(posedge clk) begin
    kpipe[0] <= k_valid ? k_x + 16'd1 : 16'hdead;
    for (int i = 1; i < KLAT; i++) kpipe[i] <= kpipe[i-1];
  end
  assign k_y = kpipe[KLAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(input int i, input logic [WIDTH-1:0] v);
    req_x[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_kx"}, 32'(k_x), 0);
    chk({tag, "_kvalid"}, 32'(k_valid), 0);
    chk({tag, "_rspv"}, 32'(rsp_valid), 0);
    chk({tag, "_rspy"}, 32'(rsp_y), 0);
  endtask

  logic [3:0]  gnt_tab [12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2};
  logic [3:0]  rsp_tab [12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2};
  logic [15:0] y_tab   [12] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0a01, 16'h0a02, 16'h0a03,
                                16'h0a04, 16'h0, 16'h0a01, 16'h0a02};
`ifdef FUNC_EVAL_SCHED_PRIO0_EN
  logic [3:0]  prio_tab [10] = '{4'h1, 4'h8, 4'h2, 4'h4, 4'h0, 4'h1, 4'h8, 4'h2, 4'h4, 4'h0};
`endif

  initial begin
    // reset state, including a request asserted during reset
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    req = 4'b1111;
    #1 chk("reset_gnt_masked", 32'(gnt), 0);
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // single requester, full latency walk
    set_x(2, 16'h4000);
    req = 4'b0100;
    #1 chk("single_gnt", 32'(gnt), 32'h4);
    tick();
    req = '0;
    chk("single_kvalid", 32'(k_valid), 1);
    chk("single_kx", 32'(k_x), 32'h4000);
    chk("single_busy_e1", 32'(busy), 32'h4);
    for (int e = 2; e <= 4; e++) begin
      tick();
      chk("single_busy_mid", 32'(busy), 32'h4);
      chk("single_rsp_early", 32'(rsp_valid), 0);
    end
    tick();
    chk("single_rspv", 32'(rsp_valid), 32'h4);
    chk("single_rspy", 32'(rsp_y), 32'h4001);
    chk("single_busy_clr", 32'(busy), 0);
    tick();
    chk("single_rspv_drop", 32'(rsp_valid), 0);
    chk("single_rspy_hold", 32'(rsp_y), 32'h4001);

`ifdef FUNC_EVAL_SCHED_PRIO0_EN
    // requester 0 taken whenever free; 1..3 rotate from pointer 3 in the gaps
    for (int i = 0; i < NREQ; i++) set_x(i, 16'h0b00 + 16'(i));
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1 chk("prio_gnt", 32'(gnt), 32'(prio_tab[c]));
      tick();
    end
    req = '0;
    repeat (8) tick();
    chk("prio_drain_busy", 32'(busy), 0);
`else
    // wrap-around from pointer 3
    set_x(0, 16'h1000);
    set_x(3, 16'h3000);
    req = 4'b1001;
    #1 chk("wrap_gnt3", 32'(gnt), 32'h8);
    tick();
    req = 4'b0001;
    chk("wrap_kx3", 32'(k_x), 32'h3000);
    #1 chk("wrap_gnt0", 32'(gnt), 32'h1);
    tick();
    req = '0;
    chk("wrap_kx0", 32'(k_x), 32'h1000);
    chk("wrap_busy", 32'(busy), 32'h9);
    tick();
    tick();
    chk("wrap_rsp_early", 32'(rsp_valid), 0);
    tick();
    chk("wrap_rspv3", 32'(rsp_valid), 32'h8);
    chk("wrap_rspy3", 32'(rsp_y), 32'h3001);
    tick();
    chk("wrap_rspv0", 32'(rsp_valid), 32'h1);
    chk("wrap_rspy0", 32'(rsp_y), 32'h1001);
    tick();
    chk("wrap_busy_clr", 32'(busy), 0);
    req = 4'b0011;
    #1 chk("wrap_ptr_is_1", 32'(gnt), 32'h2);
    req = '0;
    tick();
    chk("nogrant_kvalid", 32'(k_valid), 0);
    chk("nogrant_busy", 32'(busy), 0);
`endif

    // reset with two operands in flight
    set_x(1, 16'h0200);
    req = 4'b0010;
    #1 chk("rst_gnt1", 32'(gnt), 32'h2);
    tick();
    set_x(2, 16'h0300);
    req = 4'b0100;
    #1 chk("rst_gnt2", 32'(gnt), 32'h4);
    tick();
    req = '0;
    chk("rst_busy_pre", 32'(busy), 32'h6);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rst_no_rsp", 32'(rsp_valid), 0);
      chk("rst_busy_zero", 32'(busy), 0);
    end
    chk("rst_rspy_zero", 32'(rsp_y), 0);

    // all four requesting continuously from pointer 0
    for (int i = 0; i < NREQ; i++) set_x(i, 16'h0a00 + 16'(i));
    req = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      #1 chk("all4_gnt", 32'(gnt), 32'(gnt_tab[c]));
      chk("all4_rspv", 32'(rsp_valid), 32'(rsp_tab[c]));
      if (rsp_tab[c] != 4'h0) chk("all4_rspy", 32'(rsp_y), 32'(y_tab[c]));
      if (c > 0) chk("all4_kvalid", 32'(k_valid), 32'(gnt_tab[c-1] != 4'h0));
      tick();
    end
    req = '0;
    repeat (8) tick();
    chk("all4_drain_busy", 32'(busy), 0);

    // one requester held high: grants spaced KLAT+2 apart
    set_x(1, 16'h0555);
    req = 4'b0010;
    for (int c = 0; c <= 10; c++) begin
      #1 chk("mask_gnt", 32'(gnt), (c % 5 == 0) ? 32'h2 : 32'h0);
      chk("mask_busy", 32'(busy), (c % 5 == 0) ? 32'h0 : 32'h2);
      chk("mask_rspv", 32'(rsp_valid), (c > 0 && c % 5 == 0) ? 32'h2 : 32'h0);
      tick();
    end
    chk("mask_rspy", 32'(rsp_y), 32'h0556);
    req = '0;
    repeat (8) tick();
    chk("mask_drain_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
